// File: rtl/spmv_sequencer.sv
// Sparse matrix-vector sequencer: walks a compressed weight store row by row,
// multiply-accumulates each stored non-zero against a latched input vector on
// a single shared MAC and writes one signed result per row.
module spmv_sequencer #(
   parameter int N     = 4,
   parameter int NNZ   = 2,
   parameter int DW    = 32,
   parameter int WW    = 8,
   parameter int ACC_W = 32,
   parameter int CW    = $clog2(N),
   parameter int AW    = $clog2(N*NNZ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [N*DW-1:0]      x_in,
   output logic                 w_rd_en,
   output logic [AW-1:0]        w_addr,
   input  logic [CW+WW-1:0]     w_rdata,
   output logic [N*ACC_W-1:0]   y_out,
   output logic                 y_we,
   output logic [CW-1:0]        y_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int KW = (NNZ > 1) ? $clog2(NNZ) : 1;
   localparam int PW = (DW + WW > ACC_W) ? DW + WW : ACC_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      MAC   = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [N*DW-1:0]           r_x;
   logic [CW-1:0]             r_row;
   logic [KW-1:0]             r_k;
   logic signed [ACC_W-1:0]   r_acc;
   logic [N*ACC_W-1:0]        r_y;
   logic                      r_err;

   logic [CW-1:0]             w_col;
   logic signed [WW-1:0]      w_wt;
   logic signed [DW-1:0]      w_xSel;
   logic                      w_colOk;
   logic signed [PW-1:0]      w_prod;
   logic signed [ACC_W-1:0]   w_term;
   logic                      w_lastK;
   logic                      w_lastRow;
   logic                      w_launch;

   assign w_col     = w_rdata[CW+WW-1:WW];
   assign w_wt      = w_rdata[WW-1:0];
   assign w_lastK   = (r_k == KW'(NNZ-1));
   assign w_lastRow = (r_row == CW'(N-1));
   assign w_launch  = start && !abort;

   // Pick the vector element addressed by the fetched column; an out-of-range column matches nothing
   always_comb begin
      w_xSel  = '0;
      w_colOk = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (w_col == CW'(i)) begin
            w_xSel  = r_x[i*DW +: DW];
            w_colOk = 1'b1;
         end
      end
   end

   // Full-width signed product, then two's-complement wrap into the accumulator width
   assign w_prod = PW'(w_xSel) * PW'(w_wt);
   assign w_term = w_colOk ? w_prod[ACC_W-1:0] : '0;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode; abort from any active state returns to IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_launch ? FETCH : IDLE;
         FETCH:   w_next = abort ? IDLE : MAC;
         MAC:     w_next = abort ? IDLE : (w_lastK ? WRITE : FETCH);
         WRITE:   w_next = abort ? IDLE : (w_lastRow ? DONE : FETCH);
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: vector latch, row/entry counters, accumulator, result bank and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x   <= '0;
         r_row <= '0;
         r_k   <= '0;
         r_acc <= '0;
         r_y   <= '0;
         r_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_x   <= x_in;
                  r_row <= '0;
                  r_k   <= '0;
                  r_acc <= '0;
                  r_err <= 1'b0;
               end
            end
            MAC: begin
               r_acc <= r_acc + w_term;
               if (!w_colOk) begin
                  r_err <= 1'b1;
               end
               if (!w_lastK) begin
                  r_k <= r_k + KW'(1);
               end
            end
            WRITE: begin
               r_y[r_row*ACC_W +: ACC_W] <= r_acc;
               if (!w_lastRow) begin
                  r_row <= r_row + CW'(1);
                  r_k   <= '0;
                  r_acc <= '0;
               end
            end
            default: ;
         endcase
         if ((r_state != IDLE) && abort) begin
            r_row <= '0;
            r_k   <= '0;
            r_acc <= '0;
         end
      end
   end

   // Weight address is the flat entry index of the current row and slot
   always_comb begin
      w_addr = AW'(int'(r_row) * NNZ + int'(r_k));
   end

   assign w_rd_en = (r_state == FETCH);
   assign y_we    = (r_state == WRITE);
   assign done    = (r_state == DONE);
   assign busy    = (r_state != IDLE);
   assign y_idx   = r_row;
   assign y_out   = r_y;
   assign err     = r_err;

endmodule
